// File: rtl/token_ring_arbiter.sv
// token_ring_arbiter: N-channel token ring granting one client at a time via req/ack.
// Optional hold timeout with per-channel lockout is compiled in with TOKEN_RING_HOLD_TIMEOUT_EN.
module token_ring_arbiter #(
    parameter int  N         = 3,
    parameter int  SKIP_IDLE = 0,
    parameter int  MAX_HOLD  = 16,
    localparam int IDW       = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   ack,
    output logic [IDW-1:0] token,
    output logic           busy,
    output logic           timeout
);

    // Handshake: req is a level held by the client until it is done. When req[token]
    // is sampled in IDLE, ack[token] rises two cycles later and stays high until
    // req[token] is sampled low, after which ack falls on the next edge.

    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] token_n, token_inc, skip_idx;
    logic [N-1:0]   ack_n, req_eff;
    logic [PW-1:0]  pos_w;
    logic           skip_found;

    if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
        $error("token_ring_arbiter: parameter out of range");
    end

`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
    logic [15:0]  hold_cnt, hold_n;
    logic [N-1:0] lockout, lockout_n;
    logic         timeout_q, timeout_n;

    // A locked-out channel looks idle until its client lets go of req.
    assign req_eff = req & ~lockout;
    assign timeout = timeout_q;
`else
    assign req_eff = req;
    assign timeout = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign token_inc = (token == IDW'(N - 1)) ? '0 : token + 1'b1;

    // Nearest requester after token in ring order; scanning downwards lets the closest win.
    always_comb begin
        skip_found = 1'b0;
        skip_idx   = token;
        pos_w      = '0;
        for (int off = N - 1; off >= 1; off--) begin
            pos_w = {1'b0, token} + PW'(off);
            if (pos_w >= PW'(N)) pos_w = pos_w - PW'(N);
            if (req_eff[pos_w[IDW-1:0]]) begin
                skip_found = 1'b1;
                skip_idx   = pos_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        token_n = token;
        ack_n   = '0;
`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
        hold_n    = hold_cnt;
        lockout_n = lockout & req;
        timeout_n = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (req_eff[token]) begin
                    state_n = S_READY;
                end else if (SKIP_IDLE != 0) begin
                    if (skip_found) token_n = skip_idx;
                end else begin
                    token_n = token_inc;
                end
            end
            S_READY: begin
                state_n      = S_BUSY;
                ack_n[token] = 1'b1;
`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
                hold_n = '0;
`endif
            end
            S_BUSY: begin
                if (!req[token]) begin
                    state_n = S_IDLE;
                    token_n = token_inc;
`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
                end else if ({1'b0, hold_cnt} + 17'd1 >= 17'(MAX_HOLD)) begin
                    state_n          = S_IDLE;
                    token_n          = token_inc;
                    timeout_n        = 1'b1;
                    lockout_n[token] = 1'b1;
`endif
                end else begin
                    ack_n[token] = 1'b1;
`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
                    hold_n = hold_cnt + 16'd1;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            token <= '0;
            ack   <= '0;
        end else begin
            state <= state_n;
            token <= token_n;
            ack   <= ack_n;
        end
    end

`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            lockout   <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_n;
            lockout   <= lockout_n;
            timeout_q <= timeout_n;
        end
    end
`endif

endmodule

// File: tb/tb_token_ring_arbiter.sv
// tb_token_ring_arbiter: four arbiter configurations run side by side against a
// behavioural ring model; directed scenarios followed by random request traffic.
module tb_token_ring_arbiter;

    localparam int NI = 4;

`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk, rst;
    logic [2:0] req_a, ack_a;
    logic [3:0] req_b, ack_b;
    logic [7:0] req_c, ack_c;
    logic [4:0] req_d, ack_d;
    logic [1:0] token_a, token_b;
    logic [2:0] token_c, token_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       timeout_a, timeout_b, timeout_c, timeout_d;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         n;
        int         skip;
        int         max_hold;
        int         tok;
        int         phase;    // 0 waiting at token, 1 grant pending, 2 client holding
        int         held;
        logic [7:0] lock;
        logic [7:0] ack;
        logic       to;
    } mdl_t;

    mdl_t  m [NI];
    string nm [NI] = '{"a", "b", "c", "d"};

    token_ring_arbiter #(.N(3), .SKIP_IDLE(0), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .ack(ack_a), .token(token_a),
        .busy(busy_a), .timeout(timeout_a));
    token_ring_arbiter #(.N(4), .SKIP_IDLE(1), .MAX_HOLD(8)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .ack(ack_b), .token(token_b),
        .busy(busy_b), .timeout(timeout_b));
    token_ring_arbiter #(.N(8), .SKIP_IDLE(1), .MAX_HOLD(6)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .ack(ack_c), .token(token_c),
        .busy(busy_c), .timeout(timeout_c));
    token_ring_arbiter #(.N(5), .SKIP_IDLE(0), .MAX_HOLD(5)) u_d (
        .clk(clk), .rst(rst), .req(req_d), .ack(ack_d), .token(token_d),
        .busy(busy_d), .timeout(timeout_d));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    task automatic model_init(input int i, input int n, input int skip, input int mh);
        m[i].n = n; m[i].skip = skip; m[i].max_hold = mh;
        m[i].tok = 0; m[i].phase = 0; m[i].held = 0;
        m[i].lock = '0; m[i].ack = '0; m[i].to = 1'b0;
    endtask

    task automatic model_step(input int i, input logic r_rst, input logic [7:0] r);
        int         nt;
        logic [7:0] eff, nl;
        if (r_rst) begin
            m[i].tok = 0; m[i].phase = 0; m[i].held = 0;
            m[i].lock = '0; m[i].ack = '0; m[i].to = 1'b0;
            return;
        end
        m[i].to = 1'b0;
        nl  = TO_EN ? (m[i].lock & r) : 8'h00;
        eff = r & ~m[i].lock;
        nt  = (m[i].tok + 1) % m[i].n;
        case (m[i].phase)
            0: begin
                if (eff[m[i].tok]) m[i].phase = 1;
                else if (m[i].skip == 0) m[i].tok = nt;
                else begin
                    for (int k = 1; k < m[i].n; k++) begin
                        if (eff[(m[i].tok + k) % m[i].n]) begin
                            m[i].tok = (m[i].tok + k) % m[i].n;
                            break;
                        end
                    end
                end
            end
            1: begin
                m[i].phase = 2;
                m[i].held  = 0;
                m[i].ack   = 8'h01 << m[i].tok;
            end
            default: begin
                if (!r[m[i].tok]) begin
                    m[i].phase = 0; m[i].ack = '0; m[i].tok = nt;
                end else if (TO_EN && (m[i].held + 1 >= m[i].max_hold)) begin
                    m[i].phase = 0; m[i].ack = '0; m[i].to = 1'b1;
                    nl[m[i].tok] = 1'b1;
                    m[i].tok = nt;
                end else begin
                    m[i].held++;
                end
            end
        endcase
        m[i].lock = nl;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] a, t, b, o;
        for (int i = 0; i < NI; i++) begin
            case (i)
                0: begin a = 32'(ack_a); t = 32'(token_a); b = 32'(busy_a); o = 32'(timeout_a); end
                1: begin a = 32'(ack_b); t = 32'(token_b); b = 32'(busy_b); o = 32'(timeout_b); end
                2: begin a = 32'(ack_c); t = 32'(token_c); b = 32'(busy_c); o = 32'(timeout_c); end
                default: begin a = 32'(ack_d); t = 32'(token_d); b = 32'(busy_d); o = 32'(timeout_d); end
            endcase
            check({nm[i], ".ack"}, a, 32'(m[i].ack));
            check({nm[i], ".token"}, t, 32'(m[i].tok));
            check({nm[i], ".busy"}, b, 32'(m[i].phase != 0));
            check({nm[i], ".timeout"}, o, 32'(m[i].to));
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        model_step(0, rst, {5'b0, req_a});
        model_step(1, rst, {4'b0, req_b});
        model_step(2, rst, req_c);
        model_step(3, rst, {3'b0, req_d});
        #1;
        check_all();
    endtask

    task automatic reset_all();
        rst = 1'b1;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    int         seq [4]       = '{1, 2, 0, 1};
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    int         cnt [4];
    bit         low [4];
    logic [3:0] prev_ack;
    int         g, gi;
    bit         got;

    initial begin
        model_init(0, 3, 0, 4);
        model_init(1, 4, 1, 8);
        model_init(2, 8, 1, 6);
        model_init(3, 5, 0, 5);

        // reset and idle stepping
        reset_all();
        check("a.reset_token", 32'(token_a), 32'd0);
        check("a.reset_busy", 32'(busy_a), 32'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            if (k < 4) check("a.idle_seq", 32'(token_a), 32'(seq[k]));
            check("d.token_range", 32'(token_d < 3'd5), 32'd1);
        end

        // single grant latency on a
        for (int k = 0; k < 6 && m[0].tok != 1; k++) step();
        req_a = 3'b010;
        step();
        step();
        check("a.grant_latency", 32'(ack_a), 32'h2);
        repeat (5) step();
        check("a.grant_held", 32'(ack_a), 32'h2);
        req_a = '0;
        step();
        check("a.release_ack", 32'(ack_a), 32'h0);
        check("a.release_token", 32'(token_a), 32'd2);

        // skip and wrap on c
        req_c = 8'h40;
        step();
        check("c.skip_to_6", 32'(token_c), 32'd6);
        req_c = 8'h00;
        repeat (2) step();
        check("c.hold_at_6", 32'(token_c), 32'd6);
        req_c = 8'h04;
        step();
        check("c.wrap_to_2", 32'(token_c), 32'd2);
        step();
        step();
        check("c.wrap_grant", 32'(ack_c), 32'h04);
        req_c = 8'h00;
        step();

        // contention on b, ring-order service
        req_b = 4'hF;
        g = 0;
        prev_ack = '0;
        for (int k = 0; k < 4; k++) begin cnt[k] = 0; low[k] = 1'b0; end
        for (int k = 0; k < 80 && g < 5; k++) begin
            step();
            check("b.onehot", 32'($countones(ack_b) <= 1), 32'd1);
            if (ack_b != 4'h0 && ack_b != prev_ack) begin
                gi = 0;
                for (int ch = 0; ch < 4; ch++) if (ack_b[ch]) gi = ch;
                check("b.grant_order", 32'(gi), 32'(exp_order[g]));
                g++;
            end
            prev_ack = ack_b;
            for (int ch = 0; ch < 4; ch++) begin
                if (low[ch]) begin
                    req_b[ch] = 1'b1;
                    low[ch]   = 1'b0;
                end else if (ack_b[ch]) begin
                    cnt[ch]++;
                    if (cnt[ch] == 3) begin
                        req_b[ch] = 1'b0;
                        cnt[ch]   = 0;
                        low[ch]   = 1'b1;
                    end
                end
            end
        end
        check("b.grant_count", 32'(g), 32'd5);
        req_b = '0;
        repeat (4) step();

`ifdef TOKEN_RING_HOLD_TIMEOUT_EN
        // hold timeout and lockout on a
        reset_all();
        req_a = 3'b001;
        step();
        repeat (4) begin
            step();
            check("a.to_ack_held", 32'(ack_a), 32'h1);
        end
        step();
        check("a.to_pulse", 32'(timeout_a), 32'd1);
        check("a.to_ack_drop", 32'(ack_a), 32'h0);
        check("a.to_token", 32'(token_a), 32'd1);
        step();
        check("a.to_pulse_end", 32'(timeout_a), 32'd0);
        repeat (8) begin
            step();
            check("a.locked_out", 32'(ack_a), 32'h0);
        end
        req_a = 3'b000;
        step();
        req_a = 3'b001;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = (ack_a == 3'b001);
        end
        check("a.regrant_after_unlock", 32'(got), 32'd1);
`endif

        // reset in the middle of a grant
        reset_all();
        req_a = 3'b001;
        step();
        step();
        check("a.pre_reset_ack", 32'(ack_a), 32'h1);
        rst = 1'b1;
        step();
        check("a.reset_mid_busy_ack", 32'(ack_a), 32'h0);
        check("a.reset_mid_busy_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        req_a = '0;
        step();

        // random level requests with occasional reset
        for (int k = 0; k < 400; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            req_a = req_a ^ (3'($urandom) & 3'($urandom));
            req_b = req_b ^ (4'($urandom) & 4'($urandom));
            req_c = req_c ^ (8'($urandom) & 8'($urandom));
            req_d = req_d ^ (5'($urandom) & 5'($urandom));
            step();
        end
        rst = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/token_ring_arbiter.md
Name: token_ring_arbiter

Overview:
- Parametrised successor to the fixed three-client token-passing controller/arbiter set: a single N-channel token ring granting exclusive access through a per-channel req/ack handshake.
- Mutual exclusion holds by construction: at most one ack bit is high in any cycle.
- Adds a selectable skip-to-next-requester mode, an owner/busy status output, and an optional hold timeout.
- Sits between N client request generators and a shared resource.

Parameters:
- N, 3, number of channels; legal range 2..32.
- SKIP_IDLE, 0, token advance mode: 0 = step one position per cycle; 1 = jump to the next requesting channel in one cycle.
- MAX_HOLD, 16, maximum BUSY cycles per grant; legal range 1..65535; used only with HOLD_TIMEOUT_EN.
- IDW, derived, owner index width, equal to max(1, clog2(N)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  per-channel request; level, held by the client until it releases.
- ack  output  N  per-channel grant; one-hot or zero.
- token  output  IDW  index of the channel currently holding the token.
- busy  output  1  high in READY or BUSY.
- timeout  output  1  one-cycle pulse when a grant is revoked; constant 0 without the optional feature.

Behaviour:
- Everything is registered; there are no combinational paths from req to ack.
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE, token=0, ack=0, busy=0, timeout=0, hold counter=0, lockout mask=0.
  - Reset in the middle of a grant drops ack on the following edge with no handshake.
- FSM states: IDLE, READY, BUSY.
- IDLE:
  - If req[token]=1: go to READY; busy=1 from the next cycle.
  - Else, with SKIP_IDLE=0: token <= (token+1) mod N.
  - Else, with SKIP_IDLE=1:
    - token <= first index j with req[j]=1, searching token+1, token+2, ... wrapping modulo N, excluding token itself.
    - If no req bit is set, token holds.
- READY: lasts exactly one cycle; go to BUSY; ack[token] <= 1.
- Latency from req[token] rising (token already parked) to ack:
  - req sampled in cycle t, READY in t+1, ack visible in t+2.
- BUSY:
  - ack[token] stays at 1 while req[token]=1.
  - On sampling req[token]=0: ack <= 0, state <= IDLE, token <= (token+1) mod N, busy <= 0.
  - The releasing channel therefore never receives two grants back-to-back while another channel is waiting.
- Wrap-around: token steps from N-1 to 0. In SKIP_IDLE mode the search wraps past N-1.
- Simultaneous requests are served strictly in ring order from the current token position.
- req changes on channels other than token are ignored outside IDLE.
- If req[token] drops during READY, the grant still issues: ack=1 for at least one cycle, then the BUSY release rule applies.
- Invariant: popcount(ack) <= 1 at all times, and ack!=0 implies state=BUSY and ack[token]=1.
- Invariant: token < N at all times, including when N is not a power of 2.

Optional Feature:
- Macro: TOKEN_RING_HOLD_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on entering BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD with req[token] still 1:
    - ack <= 0 and timeout pulses for 1 cycle.
    - Token advances as on a normal release.
    - lockout[old token] <= 1.
  - A locked-out channel is treated as req=0 (for grant and for skip search) until its req is sampled 0, which clears its lockout bit.
  - Normal release in the same cycle as the counter reaching MAX_HOLD counts as a release: no timeout pulse.
- Undefined: no counter and no lockout logic; timeout is tied to 0; grants are unbounded.

Test Plan:
- Reset / idle stepping: rst=1 for 2 cycles with req=0 -> ack=0, token=0, busy=0. Then, with SKIP_IDLE=0, N=3, req=0 -> token sequence 1,2,0,1.
- Single grant latency: N=3; set req=3'b010 when token=1 -> ack=3'b010 two cycles later. Hold req 5 cycles, drop it -> ack=0 next cycle, token=2.
- Contention: N=4, SKIP_IDLE=1; req=4'b1111 held, each client drops req 3 cycles after its ack -> grants in order 0,1,2,3,0; never two ack bits set.
- Skip and wrap: N=8, SKIP_IDLE=1, token=6; req=8'b0000_0100 -> token=2 next cycle and ack[2] two cycles later. With req=0 -> token holds at 6.
- Non-power-of-2: N=5, SKIP_IDLE=0, req=0 for 12 cycles -> token cycles 0..4 and never reads 5..7.
- Timeout (macro defined, MAX_HOLD=4): req[0] held high -> ack[0] high for 4 cycles, timeout=1 for one cycle, token=1. Channel 0 is not re-granted until req[0] is dropped for 1 cycle and re-raised. Reset mid-BUSY -> ack=0 next edge.
